adder_host_ctrl: RTL and testbench

ADDER_HOST_CTRL -- requirements
Module: adder_host_ctrl

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_cycle_counter.sv | 29 ++
 rtl/adder_host_ctrl.sv | 132 +++++++++++++
 tb/tb_adder_host_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - register map, CTRL/STATUS bit positions and FSM encoding for adder_host_ctrl
package adder_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_LENGTH = 2'd2;
  localparam logic [1:0] ADDR_CYCLES = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_CLR_BIT    = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/adder_cycle_counter.sv
// rtl/adder_cycle_counter.sv - saturating cycle counter with synchronous clear and enable
module adder_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Clear has priority so a new run always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/adder_host_ctrl.sv
// rtl/adder_host_ctrl.sv - Avalon-MM host register block that launches and tracks one adder routine
module adder_host_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ADDER_HOST_CTRL_Clk,
  input  logic                  ADDER_HOST_CTRL_Reset,
  input  logic [1:0]            ADDER_HOST_CTRL_Address,
  input  logic                  ADDER_HOST_CTRL_Write,
  input  logic                  ADDER_HOST_CTRL_Read,
  input  logic [DATA_WIDTH-1:0] ADDER_HOST_CTRL_WriteData,
  output logic [DATA_WIDTH-1:0] ADDER_HOST_CTRL_ReadData,
  output logic                  ADDER_HOST_CTRL_Irq,
  output logic                  ADDER_HOST_CTRL_Start_Routine,
  output logic [LEN_WIDTH-1:0]  ADDER_HOST_CTRL_Length,
  input  logic                  ADDER_HOST_CTRL_Routine_Finished_Already,
  output logic                  ADDER_HOST_CTRL_Routine_Finished_Already_Ok
);

  import adder_pkg::*;

  logic [1:0]            r_state;
  logic                  r_done;
  logic                  r_error;
  logic                  r_irq_en;
  logic [LEN_WIDTH-1:0]  r_length;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_busy;
  logic                  w_ctrl_wr;
  logic                  w_start_req;
  logic                  w_start_ok;
  logic                  w_start_err;
  logic                  w_clr;
  logic                  w_done_set;
  logic                  w_fin;
  logic                  w_cnt_en;
  logic                  w_unused_wdata;
  logic [DATA_WIDTH-1:0] w_cycles;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_fin       = ADDER_HOST_CTRL_Routine_Finished_Already;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_ctrl_wr   = ADDER_HOST_CTRL_Write && (ADDER_HOST_CTRL_Address == ADDR_CTRL);
  assign w_start_req = w_ctrl_wr && ADDER_HOST_CTRL_WriteData[CTRL_START_BIT];
  assign w_start_ok  = w_start_req && !w_busy && (r_length != '0);
  assign w_start_err = w_start_req && !w_start_ok;
  assign w_clr       = w_ctrl_wr && ADDER_HOST_CTRL_WriteData[CTRL_CLR_BIT];
  assign w_done_set  = (r_state == ST_ACK) && !w_fin;
  assign w_cnt_en    = (r_state == ST_PULSE) || (r_state == ST_RUN);
  assign w_unused_wdata = ^ADDER_HOST_CTRL_WriteData;

  always_ff @(posedge ADDER_HOST_CTRL_Clk or posedge ADDER_HOST_CTRL_Reset) begin
    if (ADDER_HOST_CTRL_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_ok) r_state <= ST_PULSE;
        ST_PULSE: r_state <= ST_RUN;
        ST_RUN:   if (w_fin) r_state <= ST_ACK;
        ST_ACK:   if (!w_fin) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Completion outranks a clear landing on the same edge; a launch clears done.
  always_ff @(posedge ADDER_HOST_CTRL_Clk or posedge ADDER_HOST_CTRL_Reset) begin
    if (ADDER_HOST_CTRL_Reset) begin
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_irq_en <= 1'b0;
      r_length <= '0;
    end else begin
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_start_ok || w_clr) begin
        r_done <= 1'b0;
      end
      if (w_start_err) begin
        r_error <= 1'b1;
      end else if (w_clr) begin
        r_error <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= ADDER_HOST_CTRL_WriteData[CTRL_IRQ_EN_BIT];
      end
      if (ADDER_HOST_CTRL_Write && (ADDER_HOST_CTRL_Address == ADDR_LENGTH) && !w_busy) begin
        r_length <= ADDER_HOST_CTRL_WriteData[LEN_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (ADDER_HOST_CTRL_Address)
      ADDR_CTRL: w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      ADDR_STATUS: begin
        w_rdata[STAT_BUSY_BIT] = w_busy;
        w_rdata[STAT_DONE_BIT] = r_done;
        w_rdata[STAT_ERR_BIT]  = r_error;
      end
      ADDR_LENGTH: w_rdata[LEN_WIDTH-1:0] = r_length;
      default:     w_rdata = w_cycles;
    endcase
  end

  always_ff @(posedge ADDER_HOST_CTRL_Clk or posedge ADDER_HOST_CTRL_Reset) begin
    if (ADDER_HOST_CTRL_Reset) begin
      r_rdata <= '0;
    end else if (ADDER_HOST_CTRL_Read) begin
      r_rdata <= w_rdata;
    end
  end

  adder_cycle_counter #(
    .WIDTH (DATA_WIDTH)
  ) u_cycle_counter (
    .clk     (ADDER_HOST_CTRL_Clk),
    .rst     (ADDER_HOST_CTRL_Reset),
    .i_clr   (w_start_ok),
    .i_en    (w_cnt_en),
    .o_count (w_cycles)
  );

  assign ADDER_HOST_CTRL_ReadData                    = r_rdata;
  assign ADDER_HOST_CTRL_Irq                         = r_done && r_irq_en;
  assign ADDER_HOST_CTRL_Start_Routine               = (r_state == ST_PULSE);
  assign ADDER_HOST_CTRL_Length                      = r_length;
  assign ADDER_HOST_CTRL_Routine_Finished_Already_Ok = (r_state == ST_ACK);

endmodule

// File: tb/tb_adder_host_ctrl.sv
// tb/tb_adder_host_ctrl.sv - randomized self-checking bench for adder_host_ctrl with a register-level model
`timescale 1ns/1ps
module tb_adder_host_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    addr;
  logic          wr;
  logic          rd;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          irq;
  logic          start;
  logic [LW-1:0] len_o;
  logic          fin;
  logic          ok;

  always #5 clk = ~clk;

  adder_host_ctrl #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .ADDER_HOST_CTRL_Clk                         (clk),
    .ADDER_HOST_CTRL_Reset                       (rst),
    .ADDER_HOST_CTRL_Address                     (addr),
    .ADDER_HOST_CTRL_Write                       (wr),
    .ADDER_HOST_CTRL_Read                        (rd),
    .ADDER_HOST_CTRL_WriteData                   (wdata),
    .ADDER_HOST_CTRL_ReadData                    (rdata),
    .ADDER_HOST_CTRL_Irq                         (irq),
    .ADDER_HOST_CTRL_Start_Routine               (start),
    .ADDER_HOST_CTRL_Length                      (len_o),
    .ADDER_HOST_CTRL_Routine_Finished_Already    (fin),
    .ADDER_HOST_CTRL_Routine_Finished_Already_Ok (ok)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Emulated downstream adder: raises Finished fin_delay cycles after the start
  // pulse and keeps it high for fin_hold cycles of Ok.
  int fin_delay = 1;
  int fin_hold  = 1;
  int emu_phase = 0;
  int emu_cnt   = 0;
  int start_cnt = 0;
  int ok_cnt    = 0;
  int run_cnt   = 0;
  int len_glitch = 0;
  logic [LW-1:0] len_at_start = '0;

  logic          m_done;
  logic          m_error;
  logic          m_irq_en;
  logic          m_busy;
  logic [LW-1:0] m_len;
  logic [DW-1:0] m_cycles;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    fin = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fin = 1'b0;
        emu_phase = 0;
        emu_cnt = 0;
      end else begin
        if (start) start_cnt++;
        if (ok) ok_cnt++;
        if (emu_phase != 0 && len_o != len_at_start) len_glitch++;
        case (emu_phase)
          0: if (start) begin
               len_at_start = len_o;
               emu_cnt = 0;
               emu_phase = 1;
             end
          1: begin
               emu_cnt++;
               if (emu_cnt == fin_delay) begin
                 fin = 1'b1;
                 emu_cnt = 0;
                 emu_phase = 2;
               end
             end
          2: if (ok) begin
               emu_cnt++;
               if (emu_cnt == fin_hold) begin
                 fin = 1'b0;
                 emu_phase = 3;
               end
             end
          default: if (!ok) begin
               run_cnt++;
               emu_phase = 0;
             end
        endcase
      end
    end
  end

  task automatic model_reset();
    m_done = 1'b0; m_error = 1'b0; m_irq_en = 1'b0; m_busy = 1'b0;
    m_len = '0; m_cycles = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic length_write(input logic [DW-1:0] d);
    bus_write(2'd2, d);
    if (!m_busy) m_len = d[LW-1:0];
  endtask

  task automatic ctrl_write(input logic [DW-1:0] d, output bit launched);
    bus_write(2'd0, d);
    launched = 1'b0;
    m_irq_en = d[1];
    if (d[2]) begin m_done = 1'b0; m_error = 1'b0; end
    if (d[0]) begin
      if (m_busy || m_len == '0) m_error = 1'b1;
      else begin launched = 1'b1; m_done = 1'b0; m_busy = 1'b1; end
    end
  endtask

  task automatic wait_run(input int target);
    int i;
    for (i = 0; i < 500 && run_cnt != target; i++) @(negedge clk);
    if (run_cnt != target) check_eq("run_timeout", DW'(run_cnt), DW'(target));
    m_busy = 1'b0; m_done = 1'b1;
    m_cycles = DW'(1 + fin_delay);
  endtask

  task automatic check_regs(input string tag);
    logic [DW-1:0] d;
    bus_read(2'd1, d); check_eq({tag, "_status"}, d, {29'd0, m_error, m_done, m_busy});
    bus_read(2'd3, d); check_eq({tag, "_cycles"}, d, m_cycles);
    bus_read(2'd0, d); check_eq({tag, "_ctrl"}, d, {30'd0, m_irq_en, 1'b0});
    bus_read(2'd2, d); check_eq({tag, "_length"}, d, {16'd0, m_len});
    check_eq({tag, "_irq"}, DW'(irq), DW'(m_done & m_irq_en));
  endtask

  task automatic run_routine(input string tag, input logic [DW-1:0] lenv, input logic [DW-1:0] ctrl,
                             input int dly, input int hold);
    int s0, o0, r0;
    bit launched;
    fin_delay = dly; fin_hold = hold;
    length_write(lenv);
    s0 = start_cnt; o0 = ok_cnt; r0 = run_cnt; len_glitch = 0;
    ctrl_write(ctrl, launched);
    if (launched) wait_run(r0 + 1);
    else repeat (4) @(negedge clk);
    check_eq({tag, "_starts"}, DW'(start_cnt - s0), DW'(launched));
    check_eq({tag, "_ok_cycles"}, DW'(ok_cnt - o0), launched ? DW'(hold) : '0);
    if (launched) begin
      check_eq({tag, "_len_out"}, DW'(len_at_start), DW'(m_len));
      check_eq({tag, "_len_stable"}, DW'(len_glitch), '0);
    end
    check_regs(tag);
  endtask

  task automatic async_reset_release();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    bit launched;
    int s0, r0;
    rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_start", DW'(start), '0);
    check_eq("rst_ok", DW'(ok), '0);
    check_eq("rst_irq", DW'(irq), '0);
    check_eq("rst_rdata", rdata, '0);
    async_reset_release();
    check_regs("post_reset");

    run_routine("basic", 32'd8, 32'h3, 10, 1);
    run_routine("hold3", 32'd8, 32'h3, 4, 3);

    bus_write(2'd0, 32'h4);
    m_done = 1'b0; m_error = 1'b0; m_irq_en = 1'b0;
    #1 check_eq("clr_irq", DW'(irq), '0);
    check_regs("clr");

    run_routine("len0", 32'd0, 32'h1, 1, 1);

    // Second start and a LENGTH write while the first run is still going.
    bus_write(2'd0, 32'h4);
    m_done = 1'b0; m_error = 1'b0; m_irq_en = 1'b0;
    fin_delay = 8; fin_hold = 2;
    length_write(32'd5);
    s0 = start_cnt; r0 = run_cnt;
    ctrl_write(32'h1, launched);
    repeat (2) @(negedge clk);
    ctrl_write(32'h1, launched);
    length_write(32'd99);
    wait_run(r0 + 1);
    check_eq("dbl_starts", DW'(start_cnt - s0), 32'd1);
    check_regs("dbl");

    bus_write(2'd3, 32'hDEAD);
    bus_write(2'd1, 32'hFFFF_FFFF);
    check_regs("ro_wr");
    bus_read(2'd3, d);
    repeat (2) @(negedge clk);
    check_eq("rdata_hold", rdata, d);

    for (int i = 0; i < 16; i++) begin
      d2 = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_routine($sformatf("rnd%0d", i), d2, DW'($urandom_range(0, 7)),
                  $urandom_range(1, 12), $urandom_range(1, 4));
    end

    run_routine("pre_irq", 32'd3, 32'h3, 2, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 check_eq("rst_async_irq", DW'(irq), '0);
    async_reset_release();
    check_regs("rst_idle");

    length_write(32'd6);
    ctrl_write(32'h3, launched);
    #2 rst = 1'b1;
    #1 check_eq("rst_async_start", DW'(start), '0);
    async_reset_release();
    repeat (3) @(negedge clk);
    check_regs("rst_pulse");

    fin_delay = 3; fin_hold = 6;
    length_write(32'd6);
    ctrl_write(32'h3, launched);
    for (int i = 0; i < 100 && !ok; i++) @(negedge clk);
    check_eq("ack_reached", DW'(ok), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("rst_async_ok", DW'(ok), '0);
    async_reset_release();
    repeat (3) @(negedge clk);
    check_regs("rst_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
